eda_local_max_scan: RTL and testbench

- Raster-scan controller and classifier sitting directly downstream of the image window RAM.
- Drives the RAM's center address over every pixel of the M x N image and consumes the returned 3x3 window and neighbour-valid mask.
- Classifies each pixel as strict local max, plateau candidate, or non-max.
- Streams one result per pixel to the regional-max flood stage over a valid/ready handshake.

---
 rtl/eda_local_max_scan.sv | 161 ++++++++++++++++
 tb/tb_eda_local_max_scan.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eda_local_max_scan.sv
// Raster-scan controller and 3x3 local-maximum classifier feeding the regional-max flood stage.
// Optional build macro EDA_SCAN_STATS_EN adds strict/plateau result counters.
//
//   state   | meaning
//   IDLE    | waiting for start; done pulses here after a frame
//   SCAN    | walking center_addr over the image, one result per accepted load
//   DRAIN   | last pixel classified, waiting for its handshake
module eda_local_max_scan #(
   parameter int M            = 16,
   parameter int N            = 16,
   parameter int PIXEL_WIDTH  = 8,
   parameter int WINDOW_WIDTH = 9,
   parameter int I_WIDTH      = $clog2(N),
   parameter int J_WIDTH      = $clog2(M),
   parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic [ADDR_WIDTH-1:0]               center_addr,
   input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
   input  logic [7:0]                          neigh_addr_valid,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ADDR_WIDTH-1:0]               out_addr,
   output logic [1:0]                          out_class,
   output logic [7:0]                          out_eq_mask
`ifdef EDA_SCAN_STATS_EN
   ,
   output logic [ADDR_WIDTH:0]                 strict_cnt,
   output logic [ADDR_WIDTH:0]                 plateau_cnt
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [1:0] C_NOT_MAX = 2'd0;
   localparam logic [1:0] C_STRICT  = 2'd1;
   localparam logic [1:0] C_PLATEAU = 2'd2;

   localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(M - 1);
   localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(N - 1);

   logic [1:0]             state;
   logic [PIXEL_WIDTH-1:0] center_px;
   logic [PIXEL_WIDTH-1:0] neigh_px [8];
   logic [7:0]             gt_v, eq_v, lt_v;
   logic [1:0]             cls;
   logic [7:0]             cls_mask;
   logic [J_WIDTH-1:0]     j_cur;
   logic [I_WIDTH-1:0]     i_cur;
   logic                   last_pix;
   logic [ADDR_WIDTH-1:0]  next_addr;
   logic                   load;
   logic                   handshake;

   // Neighbour bit 7..0 maps to window slots 0..3 and 5..8 (slot 4 is the center).
   always_comb begin
      center_px = window_values[(WINDOW_WIDTH-4)*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
      gt_v      = '0;
      eq_v      = '0;
      lt_v      = '0;
      for (int k = 0; k < 8; k++) begin
         neigh_px[k] = window_values[(WINDOW_WIDTH-((k < 4) ? k : k+1))*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
         gt_v[7-k]   = neigh_addr_valid[7-k] && (center_px >  neigh_px[k]);
         eq_v[7-k]   = neigh_addr_valid[7-k] && (center_px == neigh_px[k]);
         lt_v[7-k]   = neigh_addr_valid[7-k] && (center_px <  neigh_px[k]);
      end
   end

   always_comb begin
      cls      = C_PLATEAU;
      cls_mask = eq_v;
      if (|lt_v) begin
         cls      = C_NOT_MAX;
         cls_mask = '0;
      end else if (gt_v == neigh_addr_valid) begin
         cls      = C_STRICT;
         cls_mask = '0;
      end
   end

   // Wrap by compare so non-power-of-two images never walk off the edge.
   always_comb begin
      j_cur    = center_addr[J_WIDTH-1:0];
      i_cur    = center_addr[ADDR_WIDTH-1:J_WIDTH];
      last_pix = (i_cur == I_LAST) && (j_cur == J_LAST);
      if (j_cur == J_LAST)
         next_addr = {i_cur + I_WIDTH'(1), {J_WIDTH{1'b0}}};
      else
         next_addr = {i_cur, j_cur + J_WIDTH'(1)};
   end

   assign load      = !out_valid || out_ready;
   assign handshake = out_valid && out_ready;
   assign busy      = (state == S_SCAN) || (state == S_DRAIN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         center_addr <= '0;
         out_valid   <= 1'b0;
         out_addr    <= '0;
         out_class   <= C_NOT_MAX;
         out_eq_mask <= '0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  center_addr <= '0;
                  state       <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (load) begin
                  out_valid   <= 1'b1;
                  out_addr    <= center_addr;
                  out_class   <= cls;
                  out_eq_mask <= cls_mask;
                  if (last_pix)
                     state <= S_DRAIN;
                  else
                     center_addr <= next_addr;
               end
            end
            S_DRAIN: begin
               if (handshake) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef EDA_SCAN_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strict_cnt  <= '0;
         plateau_cnt <= '0;
      end else if ((state == S_IDLE) && start) begin
         strict_cnt  <= '0;
         plateau_cnt <= '0;
      end else if (handshake) begin
         if (out_class == C_STRICT)
            strict_cnt <= strict_cnt + (ADDR_WIDTH+1)'(1);
         if (out_class == C_PLATEAU)
            plateau_cnt <= plateau_cnt + (ADDR_WIDTH+1)'(1);
      end
   end
`endif

endmodule

// File: tb/tb_eda_local_max_scan.sv
// Directed bench for eda_local_max_scan on a 4x4 image with a combinational window RAM model.
// Counter checks are compiled in when EDA_SCAN_STATS_EN is defined.
module tb_eda_local_max_scan;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        busy;
   logic        done;
   logic [3:0]  center_addr;
   logic [71:0] window_values;
   logic [7:0]  neigh_addr_valid;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_addr;
   logic [1:0]  out_class;
   logic [7:0]  out_eq_mask;
`ifdef EDA_SCAN_STATS_EN
   logic [4:0]  strict_cnt;
   logic [4:0]  plateau_cnt;
`endif

   logic [7:0]  img [16];
   logic [3:0]  res_addr  [32];
   logic [1:0]  res_class [32];
   logic [7:0]  res_mask  [32];
   int          checks   = 0;
   int          failures = 0;
   int          n_res;
   int          done_k;

   always #5 clk = ~clk;

   eda_local_max_scan #(.M(4), .N(4), .PIXEL_WIDTH(8), .WINDOW_WIDTH(9)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .busy             (busy),
      .done             (done),
      .center_addr      (center_addr),
      .window_values    (window_values),
      .neigh_addr_valid (neigh_addr_valid),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_addr         (out_addr),
      .out_class        (out_class),
      .out_eq_mask      (out_eq_mask)
`ifdef EDA_SCAN_STATS_EN
      ,
      .strict_cnt       (strict_cnt),
      .plateau_cnt      (plateau_cnt)
`endif
   );

   // Off-image neighbours read as 0xFF so a classifier that ignores the mask misbehaves.
   always_comb begin
      window_values    = '0;
      neigh_addr_valid = '0;
      for (int di = -1; di <= 1; di++) begin
         for (int dj = -1; dj <= 1; dj++) begin
            int ci, cj, ni, nj, w;
            logic ok;
            ci = int'(center_addr[3:2]);
            cj = int'(center_addr[1:0]);
            ni = ci + di;
            nj = cj + dj;
            w  = (di + 1) * 3 + (dj + 1);
            ok = (ni >= 0) && (ni < 4) && (nj >= 0) && (nj < 4);
            window_values[(9-w)*8-1 -: 8] = ok ? img[ni*4+nj] : 8'hFF;
            if (w < 4)
               neigh_addr_valid[7-w] = ok;
            else if (w > 4)
               neigh_addr_valid[8-w] = ok;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill_img(input logic [7:0] v);
      for (int a = 0; a < 16; a++) img[a] = v;
   endtask

   // Runs one frame; stall_at/mid_start_at/abort_at < 0 disable those events.
   task automatic do_scan(input bit pre_started, input int stall_at, input int mid_start_at,
                          input bit restart_on_done, input int abort_at,
                          output int n, output int dk);
      int         stalls;
      logic [1:0] held_class;
      n      = 0;
      dk     = -1;
      stalls = 0;
      held_class = 2'd0;
      out_ready  = 1'b1;
      if (!pre_started) begin
         @(negedge clk);
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         start = (k == mid_start_at);
         if (done) begin
            dk = k;
            if (restart_on_done) start = 1'b1;
            break;
         end
         if (abort_at >= 0 && out_valid && int'(out_addr) == abort_at) begin
            reset_n = 1'b0;
            #1;
            check_val("abort_out_valid", 32'(out_valid), 0);
            check_val("abort_busy", 32'(busy), 0);
            check_val("abort_center_addr", 32'(center_addr), 0);
            check_val("abort_out_addr", 32'(out_addr), 0);
            check_val("abort_out_class", 32'(out_class), 0);
            repeat (3) begin
               @(negedge clk);
               check_val("abort_no_done", 32'(done), 0);
            end
            reset_n = 1'b1;
            break;
         end
         if (stall_at >= 0 && out_valid && int'(out_addr) == stall_at && stalls < 3) begin
            out_ready = 1'b0;
            if (stalls == 0)
               held_class = out_class;
            else begin
               check_val("stall_addr_hold", 32'(out_addr), 32'(stall_at));
               check_val("stall_class_hold", 32'(out_class), 32'(held_class));
            end
            check_val("stall_center_frozen", 32'(center_addr), 32'(stall_at + 1));
            stalls++;
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready && n < 32) begin
            res_addr[n]  = out_addr;
            res_class[n] = out_class;
            res_mask[n]  = out_eq_mask;
            n++;
         end
      end
      if (dk < 0 && abort_at < 0)
         check_val("scan_timeout", 32'(done), 1);
   endtask

   task automatic check_frame(input string tag, input int n, input int dk, input int exp_dk);
      check_val({tag, "_count"}, 32'(n), 16);
      check_val({tag, "_done_cycle"}, 32'(dk), 32'(exp_dk));
      for (int a = 0; a < 16 && a < n; a++)
         check_val({tag, "_order"}, 32'(res_addr[a]), 32'(a));
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      fill_img(8'd5);
      repeat (3) @(negedge clk);
      check_val("rst_out_valid", 32'(out_valid), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_done", 32'(done), 0);
      check_val("rst_center_addr", 32'(center_addr), 0);
      check_val("rst_out_addr", 32'(out_addr), 0);
      check_val("rst_out_class", 32'(out_class), 0);
      check_val("rst_out_eq_mask", 32'(out_eq_mask), 0);
      reset_n = 1'b1;

      // Flat image, stray start mid-scan, restart in the done cycle.
      do_scan(1'b0, -1, 8, 1'b1, -1, n_res, done_k);
      check_frame("flat", n_res, done_k, 17);
      for (int a = 0; a < 16 && a < n_res; a++)
         check_val("flat_class", 32'(res_class[a]), 2);
      check_val("flat_mask0", 32'(res_mask[0]), 32'h0B);
      check_val("flat_mask5", 32'(res_mask[5]), 32'hFF);
      check_val("flat_mask15", 32'(res_mask[15]), 32'hD0);
      check_val("done_busy_low", 32'(busy), 0);
`ifdef EDA_SCAN_STATS_EN
      check_val("flat_strict_cnt", 32'(strict_cnt), 0);
      check_val("flat_plateau_cnt", 32'(plateau_cnt), 16);
`endif
      do_scan(1'b1, -1, -1, 1'b0, -1, n_res, done_k);
      check_frame("restart", n_res, done_k, 17);

      // Single peak at {1,2}.
      fill_img(8'd0);
      img[6] = 8'd9;
      do_scan(1'b0, -1, -1, 1'b0, -1, n_res, done_k);
      check_frame("peak", n_res, done_k, 17);
      check_val("peak_class6", 32'(res_class[6]), 1);
      check_val("peak_mask6", 32'(res_mask[6]), 0);
      check_val("peak_class2", 32'(res_class[2]), 0);
      check_val("peak_mask2", 32'(res_mask[2]), 0);
      check_val("peak_class11", 32'(res_class[11]), 0);
      check_val("peak_class0", 32'(res_class[0]), 2);
      check_val("peak_mask0", 32'(res_mask[0]), 32'h0B);
`ifdef EDA_SCAN_STATS_EN
      check_val("peak_strict_cnt", 32'(strict_cnt), 1);
      check_val("peak_plateau_cnt", 32'(plateau_cnt), 7);
`endif

      // Bright pair in the bottom-right corner; 200 vs 10 also exercises unsigned compare.
      fill_img(8'd10);
      img[15] = 8'd200;
      img[14] = 8'd200;
      do_scan(1'b0, -1, -1, 1'b0, -1, n_res, done_k);
      check_frame("corner", n_res, done_k, 17);
      check_val("corner_class15", 32'(res_class[15]), 2);
      check_val("corner_mask15", 32'(res_mask[15]), 32'h10);
      check_val("corner_class14", 32'(res_class[14]), 2);
      check_val("corner_mask14", 32'(res_mask[14]), 32'h08);
      check_val("corner_class10", 32'(res_class[10]), 0);

      // Ramp img[a]=a: only the last pixel is a strict max; stall at address 4.
      for (int a = 0; a < 16; a++) img[a] = 8'(a);
      do_scan(1'b0, 4, -1, 1'b0, -1, n_res, done_k);
      check_frame("ramp_stall", n_res, done_k, 20);
      check_val("ramp_class15", 32'(res_class[15]), 1);
      check_val("ramp_mask15", 32'(res_mask[15]), 0);
      check_val("ramp_class0", 32'(res_class[0]), 0);
      check_val("ramp_class4", 32'(res_class[4]), 0);
`ifdef EDA_SCAN_STATS_EN
      check_val("ramp_strict_cnt", 32'(strict_cnt), 1);
      check_val("ramp_plateau_cnt", 32'(plateau_cnt), 0);
`endif

      // Abort mid-frame, then a clean frame.
      fill_img(8'd5);
      do_scan(1'b0, -1, -1, 1'b0, 7, n_res, done_k);
      check_val("abort_done_k", 32'(done_k), 32'hFFFF_FFFF);
`ifdef EDA_SCAN_STATS_EN
      check_val("abort_strict_cnt", 32'(strict_cnt), 0);
      check_val("abort_plateau_cnt", 32'(plateau_cnt), 0);
`endif
      do_scan(1'b0, -1, -1, 1'b0, -1, n_res, done_k);
      check_frame("post_abort", n_res, done_k, 17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
